// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer: steps the program counter through instruction fetch using a req/ack
// handshake with instruction memory. Handles redirects, stalls and halt/resume.
module pc_fetch_sequencer #(
  parameter int unsigned        ADDR_W    = 18,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter int unsigned        INC       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic              re_PC,
  output logic              wr_PC,
  output logic [ADDR_W-1:0] pc_next,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic              instr_valid,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt,
  input  logic              resume,
  output logic              halted
);

  typedef enum logic [1:0] {S_INIT, S_ISSUE, S_WAIT, S_HALTED} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] redir_addr_q, redir_addr_d;
  logic              pend_redir_q, pend_redir_d;
  logic              pend_halt_q, pend_halt_d;

  // Next-state and handshake outputs; everything is forced idle while rst is high.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    redir_addr_d = redir_addr_q;
    pend_redir_d = pend_redir_q;
    pend_halt_d  = pend_halt_q;
    re_PC        = 1'b0;
    wr_PC        = 1'b0;
    pc_next      = '0;
    imem_req     = 1'b0;
    imem_addr    = '0;
    instr_valid  = 1'b0;

    case (state_q)
      S_INIT: begin
        wr_PC   = 1'b1;
        pc_next = RESET_VEC;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (redirect) begin
          wr_PC   = 1'b1;
          pc_next = redirect_addr;
        end else if (halt) begin
          state_d = S_HALTED;
        end else if (!stall) begin
          re_PC        = 1'b1;
          imem_req     = 1'b1;
          imem_addr    = pc_cur;
          fetch_addr_d = pc_cur;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        imem_req  = 1'b1;
        imem_addr = fetch_addr_q;
        if (imem_ack) begin
          wr_PC = 1'b1;
          // A redirect seen at any point during the fetch squashes the instruction.
          if (redirect) begin
            pc_next = redirect_addr;
          end else if (pend_redir_q) begin
            pc_next = redir_addr_q;
          end else begin
            instr_valid = 1'b1;
            pc_next     = fetch_addr_q + ADDR_W'(INC);
          end
          pend_redir_d = 1'b0;
          pend_halt_d  = 1'b0;
          state_d      = (pend_halt_q || halt) ? S_HALTED : S_ISSUE;
        end else begin
          if (redirect) begin
            pend_redir_d = 1'b1;
            redir_addr_d = redirect_addr;
          end
          if (halt) begin
            pend_halt_d = 1'b1;
          end
        end
      end
      S_HALTED: begin
        if (redirect) begin
          wr_PC   = 1'b1;
          pc_next = redirect_addr;
        end
        if (resume && !halt) begin
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_INIT;
    endcase

    if (rst) begin
      re_PC       = 1'b0;
      wr_PC       = 1'b0;
      pc_next     = '0;
      imem_req    = 1'b0;
      imem_addr   = '0;
      instr_valid = 1'b0;
    end
  end

  assign halted = (state_q == S_HALTED) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      fetch_addr_q <= '0;
      redir_addr_q <= '0;
      pend_redir_q <= 1'b0;
      pend_halt_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      redir_addr_q <= redir_addr_d;
      pend_redir_q <= pend_redir_d;
      pend_halt_q  <= pend_halt_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed boot/redirect/halt/reset scenarios plus a randomized
// run checked cycle by cycle against a transaction-level fetch model.
module tb_pc_fetch_sequencer;
  localparam int unsigned AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall, redirect, halt, resume, imem_ack;
  logic [AW-1:0] redirect_addr;

  logic          re_pc, wr_pc, req, valid, hlt;
  logic [AW-1:0] pc_nxt, addr, pc_q;
  logic          w_re, w_wr, w_req, w_valid, w_hlt;
  logic [AW-1:0] w_pc_nxt, w_addr, w_pc_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.ADDR_W(AW), .RESET_VEC(18'd0), .INC(1)) u_dut (
    .clk(clk), .rst(rst), .pc_cur(pc_q), .re_PC(re_pc), .wr_PC(wr_pc), .pc_next(pc_nxt),
    .imem_req(req), .imem_addr(addr), .imem_ack(imem_ack), .instr_valid(valid),
    .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr), .halt(halt),
    .resume(resume), .halted(hlt));

  pc_fetch_sequencer #(.ADDR_W(AW), .RESET_VEC(18'h3FFFF), .INC(1)) u_wrap (
    .clk(clk), .rst(rst), .pc_cur(w_pc_q), .re_PC(w_re), .wr_PC(w_wr), .pc_next(w_pc_nxt),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(imem_ack), .instr_valid(w_valid),
    .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr), .halt(halt),
    .resume(resume), .halted(w_hlt));

  // PC registers driven by the sequencers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      w_pc_q <= '0;
    end else begin
      if (wr_pc) pc_q <= pc_nxt;
      if (w_wr) w_pc_q <= w_pc_nxt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; redirect = 1'b0; halt = 1'b0; resume = 1'b0; imem_ack = 1'b0;
    redirect_addr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({re_pc, wr_pc, req, valid, hlt, pc_nxt, addr} !== 41'd0) begin
      errors++;
      $display("FAIL reset_idle: got %h expected 0", {re_pc, wr_pc, req, valid, hlt, pc_nxt, addr});
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_pc !== 1'b1 || pc_nxt !== 18'd0 || req !== 1'b0) begin
      errors++;
      $display("FAIL init: wr=%b pc_next=%h req=%b expected wr=1 pc_next=0 req=0", wr_pc, pc_nxt, req);
    end
    checks++;
    if (w_wr !== 1'b1 || w_pc_nxt !== 18'h3FFFF) begin
      errors++;
      $display("FAIL init_vec: wr=%b pc_next=%h expected wr=1 pc_next=3ffff", w_wr, w_pc_nxt);
    end
    tick();
    @(negedge clk);
    checks++;
    if (req !== 1'b1 || re_pc !== 1'b1 || addr !== 18'd0 || wr_pc !== 1'b0) begin
      errors++;
      $display("FAIL boot_fetch: req=%b re=%b addr=%h wr=%b expected 1 1 0 0", req, re_pc, addr, wr_pc);
    end
    checks++;
    if (w_req !== 1'b1 || w_addr !== 18'h3FFFF) begin
      errors++;
      $display("FAIL wrap_fetch: req=%b addr=%h expected 1 3ffff", w_req, w_addr);
    end
    tick();
    imem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || wr_pc !== 1'b1 || pc_nxt !== 18'd1) begin
      errors++;
      $display("FAIL boot_ack: valid=%b wr=%b pc_next=%h expected 1 1 1", valid, wr_pc, pc_nxt);
    end
    checks++;
    if (w_valid !== 1'b1 || w_wr !== 1'b1 || w_pc_nxt !== 18'd0) begin
      errors++;
      $display("FAIL wrap_ack: valid=%b wr=%b pc_next=%h expected 1 1 0", w_valid, w_wr, w_pc_nxt);
    end
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (req !== 1'b1 || addr !== AW'(i) || valid !== 1'b0) begin
        errors++;
        $display("FAIL seq_issue[%0d]: req=%b addr=%h valid=%b expected 1 %h 0", i, req, addr, valid, AW'(i));
      end
      tick();
      imem_ack = 1'b1;
      @(negedge clk);
      checks++;
      if (valid !== 1'b1 || wr_pc !== 1'b1 || pc_nxt !== AW'(i + 1)) begin
        errors++;
        $display("FAIL seq_ack[%0d]: valid=%b wr=%b pc_next=%h expected 1 1 %h", i, valid, wr_pc, pc_nxt, AW'(i + 1));
      end
      tick();
      imem_ack = 1'b0;
    end
  endtask

  task automatic test_redirect();
    do_reset();
    tick();
    redirect = 1'b1;
    redirect_addr = 18'h00100;
    @(negedge clk);
    checks++;
    if (wr_pc !== 1'b0 || req !== 1'b1 || addr !== 18'd0) begin
      errors++;
      $display("FAIL redir_pend: wr=%b req=%b addr=%h expected 0 1 0", wr_pc, req, addr);
    end
    tick();
    redirect = 1'b0;
    redirect_addr = '0;
    @(negedge clk);
    checks++;
    if (req !== 1'b1 || addr !== 18'd0) begin
      errors++;
      $display("FAIL redir_hold: req=%b addr=%h expected 1 0", req, addr);
    end
    tick();
    imem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || wr_pc !== 1'b1 || pc_nxt !== 18'h00100) begin
      errors++;
      $display("FAIL redir_squash: valid=%b wr=%b pc_next=%h expected 0 1 100", valid, wr_pc, pc_nxt);
    end
    tick();
    imem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (req !== 1'b1 || addr !== 18'h00100) begin
      errors++;
      $display("FAIL redir_fetch: req=%b addr=%h expected 1 100", req, addr);
    end
  endtask

  task automatic test_halt();
    do_reset();
    tick();
    halt = 1'b1;
    @(negedge clk);
    tick();
    halt = 1'b0;
    imem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || pc_nxt !== 18'd1 || hlt !== 1'b0) begin
      errors++;
      $display("FAIL halt_ack: valid=%b pc_next=%h halted=%b expected 1 1 0", valid, pc_nxt, hlt);
    end
    tick();
    imem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      resume = (k == 4);
      @(negedge clk);
      checks++;
      if (hlt !== 1'b1 || req !== 1'b0) begin
        errors++;
        $display("FAIL halted[%0d]: halted=%b req=%b expected 1 0", k, hlt, req);
      end
      tick();
    end
    resume = 1'b0;
    @(negedge clk);
    checks++;
    if (hlt !== 1'b0 || req !== 1'b1 || addr !== 18'd1) begin
      errors++;
      $display("FAIL resume_fetch: halted=%b req=%b addr=%h expected 0 1 1", hlt, req, addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    tick();
    @(negedge clk);
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({re_pc, wr_pc, req, valid, hlt, pc_nxt, addr} !== 41'd0) begin
      errors++;
      $display("FAIL rst_mid: got %h expected 0", {re_pc, wr_pc, req, valid, hlt, pc_nxt, addr});
    end
    tick();
    rst = 1'b0;
    imem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || wr_pc !== 1'b1 || pc_nxt !== 18'd0) begin
      errors++;
      $display("FAIL late_ack: valid=%b wr=%b pc_next=%h expected 0 1 0", valid, wr_pc, pc_nxt);
    end
    tick();
    imem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (req !== 1'b1 || addr !== 18'd0) begin
      errors++;
      $display("FAIL restart: req=%b addr=%h expected 1 0", req, addr);
    end
  endtask

  // Randomized run: the model tracks the architectural PC, the one outstanding fetch,
  // whether it has been squashed, and the halted/run mode.
  task automatic test_random();
    logic [AW-1:0] m_pc, m_faddr, m_sq_tgt, tgt;
    bit            m_fl, m_sq, m_hp, m_halted;
    int            wcnt;
    logic          e_re, e_wr, e_req, e_val, e_hlt;
    logic [AW-1:0] e_pcn, e_addr;
    do_reset();
    m_pc = '0; m_faddr = '0; m_sq_tgt = '0;
    m_fl = 0; m_sq = 0; m_hp = 0; m_halted = 0; wcnt = 0;
    for (int c = 0; c < 600; c++) begin
      stall         = ($urandom_range(0, 4) == 0);
      redirect      = ($urandom_range(0, 9) == 0);
      redirect_addr = AW'($urandom);
      halt          = ($urandom_range(0, 19) == 0);
      resume        = ($urandom_range(0, 4) == 0);
      imem_ack      = 1'b0;
      if (m_fl) begin
        if (wcnt == 0) imem_ack = 1'b1;
        else wcnt--;
      end
      @(negedge clk);
      e_re = 0; e_wr = 0; e_req = 0; e_val = 0; e_hlt = 0; e_pcn = '0; e_addr = '0;
      if (m_halted) begin
        e_hlt = 1;
        if (redirect) begin
          e_wr = 1; e_pcn = redirect_addr; m_pc = redirect_addr;
        end
        if (resume && !halt) m_halted = 0;
      end else if (m_fl) begin
        e_req = 1; e_addr = m_faddr;
        if (imem_ack) begin
          if (redirect) tgt = redirect_addr;
          else if (m_sq) tgt = m_sq_tgt;
          else tgt = m_faddr + AW'(1);
          e_val = !(redirect || m_sq);
          e_wr = 1; e_pcn = tgt; m_pc = tgt;
          m_halted = m_hp || halt;
          m_fl = 0; m_sq = 0; m_hp = 0;
        end else begin
          if (redirect) begin
            m_sq = 1; m_sq_tgt = redirect_addr;
          end
          if (halt) m_hp = 1;
        end
      end else if (redirect) begin
        e_wr = 1; e_pcn = redirect_addr; m_pc = redirect_addr;
      end else if (halt) begin
        m_halted = 1;
      end else if (!stall) begin
        e_re = 1; e_req = 1; e_addr = m_pc;
        m_fl = 1; m_faddr = m_pc; wcnt = $urandom_range(0, 3);
      end
      checks++;
      if ({re_pc, wr_pc, pc_nxt, req, addr, valid, hlt} !== {e_re, e_wr, e_pcn, e_req, e_addr, e_val, e_hlt}) begin
        errors++;
        $display("FAIL random[%0d]: got re=%b wr=%b pcn=%h req=%b addr=%h val=%b hlt=%b expected re=%b wr=%b pcn=%h req=%b addr=%h val=%b hlt=%b",
                 c, re_pc, wr_pc, pc_nxt, req, addr, valid, hlt, e_re, e_wr, e_pcn, e_req, e_addr, e_val, e_hlt);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_halt();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
